// File: rtl/pattern_sequencer_pkg.sv
// Shared definitions for the pattern sequencer: FSM states, pattern word opcodes and field positions.
package pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  localparam int WORD_W  = 16;
  localparam int PITCH_W = 6;
  localparam int DUR_W   = 4;

  localparam logic [1:0] OP_NOTE = 2'b00;
  localparam logic [1:0] OP_REST = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;
  localparam logic [1:0] OP_END  = 2'b11;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 14;
  localparam int RSVD_HI  = 13;
  localparam int RSVD_LO  = 10;
  localparam int DUR_HI   = 9;
  localparam int DUR_LO   = 6;
  localparam int PITCH_HI = 5;
  localparam int PITCH_LO = 0;

  localparam logic [DUR_W-1:0] HALT_DURATION = 4'hF;

endpackage

// File: rtl/pattern_sequencer.sv
// Fetches and decodes pattern ROM words on request, following JUMPs and halting on END or a jump loop.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_restart,
  output logic                o_rom_en,
  output logic [ADDR_W-1:0]   o_rom_addr,
  input  logic [WORD_W-1:0]   i_rom_data,
  output logic                o_valid,
  output logic [PITCH_W-1:0]  o_pitch,
  output logic [DUR_W-1:0]    o_duration,
  output logic                o_rest,
  output logic                o_busy,
  output logic                o_halted
);

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    pc;
  logic                 jump_cnt;
  logic [1:0]           op;
  logic                 ev_fire;
  logic [PITCH_W-1:0]   ev_pitch;
  logic [DUR_W-1:0]     ev_dur;
  logic                 ev_rest;
  logic                 unused_rsvd;

  assign op          = i_rom_data[OP_HI:OP_LO];
  assign unused_rsvd = ^i_rom_data[RSVD_HI:RSVD_LO];
  assign o_rom_addr  = pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Restart overrides everything; a simultaneous request is serviced from START_ADDR.
  always_comb begin
    state_nxt = state;
    if (i_restart) begin
      state_nxt = i_enable ? ST_FETCH : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (i_enable && !o_halted) state_nxt = ST_FETCH;
        ST_FETCH:  state_nxt = ST_DECODE;
        ST_DECODE: state_nxt = (op == OP_JUMP && !jump_cnt) ? ST_FETCH : ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy   = (state != ST_IDLE);
    o_rom_en = (state == ST_FETCH);
  end

  // Event to publish next cycle; defaults describe the halt rest event.
  always_comb begin
    ev_fire  = 1'b0;
    ev_pitch = '0;
    ev_dur   = HALT_DURATION;
    ev_rest  = 1'b1;
    if (!i_restart) begin
      if (state == ST_IDLE && i_enable && o_halted) begin
        ev_fire = 1'b1;
      end else if (state == ST_DECODE) begin
        case (op)
          OP_NOTE: begin
            ev_fire  = 1'b1;
            ev_pitch = i_rom_data[PITCH_HI:PITCH_LO];
            ev_dur   = i_rom_data[DUR_HI:DUR_LO];
            ev_rest  = 1'b0;
          end
          OP_REST: begin
            ev_fire = 1'b1;
            ev_dur  = i_rom_data[DUR_HI:DUR_LO];
          end
          OP_JUMP: ev_fire = jump_cnt;
          default: ev_fire = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc         <= START_ADDR;
      jump_cnt   <= 1'b0;
      o_halted   <= 1'b0;
      o_valid    <= 1'b0;
      o_pitch    <= '0;
      o_duration <= '0;
      o_rest     <= 1'b0;
    end else begin
      o_valid <= ev_fire;
      if (ev_fire) begin
        o_pitch    <= ev_pitch;
        o_duration <= ev_dur;
        o_rest     <= ev_rest;
      end
      if (i_restart) begin
        pc       <= START_ADDR;
        jump_cnt <= 1'b0;
        o_halted <= 1'b0;
      end else if (state == ST_DECODE) begin
        if (op == OP_NOTE || op == OP_REST) begin
          pc       <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          jump_cnt <= 1'b0;
        end else if (op == OP_JUMP && !jump_cnt) begin
          pc       <= i_rom_data[ADDR_W-1:0];
          jump_cnt <= 1'b1;
        end else begin
          o_halted <= 1'b1;
          jump_cnt <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed vector table, hand-written restart/reset sequences, randomized model check.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, restart;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        valid, rest, busy, halted;
  logic [5:0]  pitch;
  logic [3:0]  duration;

  pattern_sequencer #(.ADDR_W(8), .START_ADDR(8'd0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_restart(restart),
    .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_valid(valid), .o_pitch(pitch), .o_duration(duration), .o_rest(rest),
    .o_busy(busy), .o_halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  int errors = 0;
  int checks = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Captured response of one request
  int         got_lat;
  logic [5:0] got_pitch;
  logic [3:0] got_dur;
  logic       got_rest, got_halted, got_after;
  logic [7:0] got_addr[$];

  task automatic request(input bit with_rst, input bit spurious);
    int cyc;
    got_addr.delete();
    got_lat = -1;
    @(negedge clk);
    enable  = 1'b1;
    restart = with_rst;
    cyc = 0;
    while (got_lat < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      enable  = 1'b0;
      restart = 1'b0;
      if (rom_en) got_addr.push_back(rom_addr);
      if (valid) begin
        got_lat    = cyc;
        got_pitch  = pitch;
        got_dur    = duration;
        got_rest   = rest;
        got_halted = halted;
      end else if (spurious && cyc == 1 && busy) begin
        enable = 1'b1;
      end
    end
    enable = 1'b0;
    @(negedge clk);
    got_after = valid;
  endtask

  task automatic compare(string tag, int lat, int nf, int a0, int p, int d, int r, int h);
    check($sformatf("%s latency", tag), got_lat, lat);
    check($sformatf("%s fetches", tag), got_addr.size(), nf);
    if (nf > 0 && got_addr.size() > 0) check($sformatf("%s first_addr", tag), got_addr[0], a0);
    check($sformatf("%s pitch", tag), got_pitch, p);
    check($sformatf("%s duration", tag), got_dur, d);
    check($sformatf("%s rest", tag), got_rest, r);
    check($sformatf("%s halted", tag), got_halted, h);
    check($sformatf("%s valid_one_cycle", tag), got_after, 0);
  endtask

  // Reference model: walks the ROM by the word rules, counting fetches
  logic [7:0] m_pc;
  bit         m_halted;
  logic [7:0] exp_addr[$];

  function automatic void model_req(output int lat, output int p, output int d, output int r);
    logic [15:0] w;
    bit done;
    int jumps;
    exp_addr.delete();
    p = 0; d = 15; r = 1;
    if (m_halted) begin
      lat = 1;
      return;
    end
    jumps = 0;
    done  = 0;
    while (!done) begin
      exp_addr.push_back(m_pc);
      w = rom[m_pc];
      case (w[15:14])
        2'b00: begin p = w[5:0]; d = w[9:6]; r = 0; m_pc = m_pc + 8'd1; done = 1; end
        2'b01: begin d = w[9:6]; m_pc = m_pc + 8'd1; done = 1; end
        2'b10: begin
          if (jumps == 1) begin m_halted = 1; done = 1; end
          else begin jumps = 1; m_pc = w[7:0]; end
        end
        default: begin m_halted = 1; done = 1; end
      endcase
    end
    lat = 1 + 2 * exp_addr.size();
  endfunction

  typedef struct {
    bit          patch;
    logic [7:0]  paddr;
    logic [15:0] pword;
    bit          rst;
    int lat; int nf; int a0; int p; int d; int r; int h;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    int seen;
    int lat, p, d, r;
    logic [15:0] w;
    logic [31:0] rnd;

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h00CC;  // NOTE p=12 d=3
    rom[1] = 16'h4140;  // REST d=5
    rom[2] = 16'h8000;  // JUMP 0
    rom[3] = 16'h0268;  // NOTE p=40 d=9
    rom[4] = 16'hC000;  // END
    rom[6] = 16'h8006;  // JUMP 6

    vecs[0] = '{0, 8'd0, 16'h0000, 0, 3, 1, 0, 12, 3, 0, 0};
    vecs[1] = '{0, 8'd0, 16'h0000, 0, 3, 1, 1, 0, 5, 1, 0};
    vecs[2] = '{0, 8'd0, 16'h0000, 0, 5, 2, 2, 12, 3, 0, 0};
    vecs[3] = '{0, 8'd0, 16'h0000, 0, 3, 1, 1, 0, 5, 1, 0};
    vecs[4] = '{1, 8'd2, 16'h8003, 0, 5, 2, 2, 40, 9, 0, 0};
    vecs[5] = '{0, 8'd0, 16'h0000, 0, 3, 1, 4, 0, 15, 1, 1};
    vecs[6] = '{0, 8'd0, 16'h0000, 0, 1, 0, 0, 0, 15, 1, 1};
    vecs[7] = '{1, 8'd0, 16'h8006, 1, 5, 2, 0, 0, 15, 1, 1};
    vecs[8] = '{1, 8'd0, 16'h00CC, 1, 3, 1, 0, 12, 3, 0, 0};
    vecs[9] = '{1, 8'd1, 16'h7D4A, 0, 3, 1, 1, 0, 5, 1, 0};

    rst_n = 1'b0; enable = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    check("reset valid", valid, 0);
    check("reset busy", busy, 0);
    check("reset rom_en", rom_en, 0);
    check("reset rom_addr", rom_addr, 0);
    check("reset halted", halted, 0);
    check("reset outputs", {pitch, duration, rest}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", busy, 0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].patch) rom[vecs[i].paddr] = vecs[i].pword;
      if (vecs[i].rst) begin
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        check($sformatf("vec%0d restart clears halt", i), halted, 0);
      end
      request(0, i % 2 == 1);
      compare($sformatf("vec%0d", i), vecs[i].lat, vecs[i].nf, vecs[i].a0,
              vecs[i].p, vecs[i].d, vecs[i].r, vecs[i].h);
    end

    // Restart during FETCH aborts the request; PC at 2 beforehand
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    check("abort fetch rom_en", rom_en, 1);
    check("abort fetch addr", rom_addr, 2);
    restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid) seen++;
      @(negedge clk);
    end
    check("abort no valid", seen, 0);
    check("abort busy", busy, 0);
    check("abort pc", rom_addr, 0);
    request(0, 0);
    compare("after_abort", 3, 1, 0, 12, 3, 0, 0);

    // Restart with enable in the same cycle; then the same from the halted state
    request(1, 0);
    compare("restart_enable", 3, 1, 0, 12, 3, 0, 0);
    rom[1] = 16'hC000;
    request(0, 0);
    compare("end_again", 3, 1, 1, 0, 15, 1, 1);
    request(1, 0);
    compare("restart_enable_halted", 3, 1, 0, 12, 3, 0, 0);

    // Randomized phase against the model
    for (int i = 0; i < 256; i++) begin
      rnd = $urandom();
      w = rnd[15:0];
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: w[15:14] = 2'b00;
        5, 6:          w[15:14] = 2'b01;
        7, 8:          w[15:14] = 2'b10;
        default:       w[15:14] = 2'b11;
      endcase
      rom[i] = w;
    end
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    m_pc = 8'd0; m_halted = 0;
    for (int n = 0; n < 150; n++) begin
      bit wr;
      wr = m_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      if (wr) begin m_pc = 8'd0; m_halted = 0; end
      model_req(lat, p, d, r);
      request(wr, $urandom_range(0, 1) == 1);
      compare($sformatf("rand%0d", n), lat, exp_addr.size(),
              exp_addr.size() > 0 ? int'(exp_addr[0]) : 0, p, d, r, int'(m_halted));
      for (int k = 1; k < exp_addr.size() && k < got_addr.size(); k++)
        check($sformatf("rand%0d addr%0d", n, k), got_addr[k], exp_addr[k]);
    end

    // Asynchronous reset in the middle of a fetch
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset rom_en", rom_en, 0);
    check("async reset addr", rom_addr, 0);
    check("async reset outputs", {valid, halted, pitch, duration, rest}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
